// File: rtl/bus_master_interface_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : bus_master_interface_if
// Description : Client request/response handshake and system-bus control
//               signals for the single bus master.
//               master modport : view taken by bus_master_interface
//               slave  modport : view taken by the client / bus fabric side
// Signals     : req_valid/req_ready/req_write/req_addr/req_wdata/req_mask,
//               resp_valid/resp_rdata/resp_error, busy,
//               addr_bus/rd_bus/wr_bus/data_mask_bus, fc_bus
//               (the bidirectional data_bus is a resolved net and is carried
//               as a plain inout port of the master instead)
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_master_interface_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        busy;
  logic [31:0] addr_bus;
  logic        rd_bus;
  logic        wr_bus;
  logic [3:0]  data_mask_bus;
  logic        fc_bus;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_mask, fc_bus,
    output req_ready, resp_valid, resp_rdata, resp_error, busy,
           addr_bus, rd_bus, wr_bus, data_mask_bus
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_mask, fc_bus,
    input  req_ready, resp_valid, resp_rdata, resp_error, busy,
           addr_bus, rd_bus, wr_bus, data_mask_bus
  );
endinterface
`default_nettype wire

// File: rtl/bus_master_interface.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : bus_master_interface
// Description : Initiator side of the shared system bus. Accepts one read or
//               write request at a time from a client, drives the bus until
//               the addressed device raises fc_bus, then returns read data or
//               a write completion as a one-cycle resp_valid pulse. A DONE
//               cycle with the bus released separates every two transactions.
// Ports       : clk      - system clock, rising edge
//               rst      - asynchronous reset, active low
//               bus      - bus_master_interface_if.master (handshake + bus)
//               data_bus - 32-bit bidirectional data, driven only on writes
// Options     : BUS_MASTER_TIMEOUT_EN - when defined, an 8-bit counter aborts
//               a REQ phase after TIMEOUT_CYCLES cycles (1..255) with
//               resp_error = 1. When undefined REQ waits indefinitely and
//               resp_error stays 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_master_interface #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic              clk,
  input  wire logic              rst,
  bus_master_interface_if.master bus,
  inout  wire [31:0]             data_bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        write_q, write_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q,  mask_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic fc_w;
  logic timeout_w;
  logic in_req_w;

  // Only a clean logic 1 counts; a floating/unknown fc_bus never completes.
  assign fc_w     = (bus.fc_bus == 1'b1);
  assign in_req_w = (state_q == ST_REQ);

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  // cnt_q counts completed REQ cycles, so the edge that closes the
  // TIMEOUT_CYCLES-th REQ cycle sees cnt_q == TIMEOUT_CYCLES-1.
  assign timeout_w = in_req_w && (cnt_q == TIMEOUT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) begin
      cnt_d = 8'd0;
    end else if (in_req_w && !fc_w) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          mask_d  = bus.req_mask;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // Completion on the same edge as the timeout takes priority.
        if (fc_w) begin
          rdata_d = write_q ? 32'h0 : data_bus;
          error_d = 1'b0;
          state_d = ST_DONE;
        end else if (timeout_w) begin
          rdata_d = 32'h0;
          error_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      mask_q  <= 4'h0;
      rdata_q <= 32'h0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Client side
  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.resp_valid = (state_q == ST_DONE);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = error_q;

  // Bus side: strobes and lane mask exist only during REQ; the address
  // register is only loaded on accept, so addr_bus holds between requests.
  assign bus.addr_bus      = addr_q;
  assign bus.rd_bus        = in_req_w && !write_q;
  assign bus.wr_bus        = in_req_w &&  write_q;
  assign bus.data_mask_bus = in_req_w ? mask_q : 4'h0;
  assign data_bus          = (in_req_w && write_q) ? wdata_q : {32{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_bus_master_interface.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bus_master_interface
// Description : Self-checking bench for bus_master_interface. A responder
//               device derives its latency and read data from the address;
//               a transaction-level timeline model predicts every output on
//               every cycle, and directed cases pin literal latencies/data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_master_interface;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bus_master_interface_if bif();
  wire [31:0] data_bus;

  bus_master_interface #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bif.master),
    .data_bus (data_bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_released(input string name);
    checks++;
    if (!(data_bus === {32{1'bz}} || data_bus === 32'h0)) begin
      errors++;
      $display("FAIL %s: data_bus=%h expected released (cycle %0d)", name, data_bus, cyc);
    end
  endtask

  // ---------------- device model: behaviour is a function of the address --
  // latency = REQ cycle (1-based) in which fc rises; 0 = unmapped (never)
  function automatic int lat_of(input logic w, input logic [31:0] a);
    if (a[31]) return 0;
    return int'(a[5:4]) + (w ? 2 : 1);
  endfunction

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a * 32'h0040_0040;
  endfunction

  logic fc_noise = 1'b0;
  int   rsp_cnt  = 0;
  int   cur_d;

  always @(posedge clk) rsp_cnt <= (bif.rd_bus || bif.wr_bus) ? rsp_cnt + 1 : 0;
  always @(negedge clk) fc_noise <= 1'($urandom);

  assign cur_d      = lat_of(bif.wr_bus, bif.addr_bus);
  // Outside a bus cycle fc_bus toggles randomly; the master must ignore it.
  assign bif.fc_bus = (bif.rd_bus || bif.wr_bus) ? (cur_d != 0 && rsp_cnt + 1 >= cur_d) : fc_noise;
  assign data_bus   = (bif.rd_bus && !bif.wr_bus) ? rd_of(bif.addr_bus) : {32{1'bz}};

  // ---------------- transaction-level expectation ------------------------
  function automatic int k_of(input logic w, input logic [31:0] a);
    int d;
    d = lat_of(w, a);
`ifdef BUS_MASTER_TIMEOUT_EN
    if (d == 0 || d > TMO) return TMO;
`endif
    return d;
  endfunction

  function automatic logic err_of(input logic w, input logic [31:0] a);
    int d;
    d = lat_of(w, a);
`ifdef BUS_MASTER_TIMEOUT_EN
    return (d == 0 || d > TMO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] rsp_of(input logic w, input logic [31:0] a);
    if (err_of(w, a) || w) return 32'h0;
    return rd_of(a);
  endfunction

  // Cycle c is the interval after posedge number c. A transaction accepted at
  // posedge m_acc occupies the bus in cycles m_acc .. m_acc+m_k-1 and
  // responds in cycle m_acc+m_k.
  logic        m_busy = 1'b0;
  int          m_acc  = 0;
  int          m_k    = 0;
  logic        m_write = 1'b0;
  logic [31:0] m_wdata = 32'h0;
  logic [3:0]  m_mask  = 4'h0;
  logic [31:0] m_rdata = 32'h0;
  logic        m_err   = 1'b0;
  logic [31:0] exp_addr   = 32'h0;
  logic [31:0] hold_rdata = 32'h0;
  logic        hold_err   = 1'b0;

  // 0 = idle, 1 = bus request, 2 = response
  function automatic int phase(input int c);
    if (!m_busy) return 0;
    if (c < m_acc + m_k) return 1;
    if (c == m_acc + m_k) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      m_busy     <= 1'b0;
      exp_addr   <= 32'h0;
      hold_rdata <= 32'h0;
      hold_err   <= 1'b0;
    end else if (phase(cyc) == 0 && bif.req_valid) begin
      hold_rdata <= m_busy ? m_rdata : hold_rdata;
      hold_err   <= m_busy ? m_err   : hold_err;
      m_busy     <= 1'b1;
      m_acc      <= cyc + 1;
      m_k        <= k_of(bif.req_write, bif.req_addr);
      m_write    <= bif.req_write;
      m_wdata    <= bif.req_wdata;
      m_mask     <= bif.req_mask;
      m_rdata    <= rsp_of(bif.req_write, bif.req_addr);
      m_err      <= err_of(bif.req_write, bif.req_addr);
      exp_addr   <= bif.req_addr;
    end
  end

  // ---------------- per-cycle comparison ---------------------------------
  int          cmp_ph;
  logic        cmp_done;
  always @(negedge clk) begin
    if (!rst) begin
      check("rst req_ready", bif.req_ready, 1'b1);
      check("rst resp_valid", bif.resp_valid, 1'b0);
      check("rst resp_error", bif.resp_error, 1'b0);
      check("rst busy", bif.busy, 1'b0);
      check("rst rd_bus", bif.rd_bus, 1'b0);
      check("rst wr_bus", bif.wr_bus, 1'b0);
      check("rst addr_bus", bif.addr_bus, 32'h0);
      check("rst mask", bif.data_mask_bus, 4'h0);
      check("rst resp_rdata", bif.resp_rdata, 32'h0);
      check_released("rst data_bus");
    end else begin
      cmp_ph   = phase(cyc);
      cmp_done = m_busy && (cyc >= m_acc + m_k);
      check("req_ready", bif.req_ready, cmp_ph == 0);
      check("busy", bif.busy, cmp_ph != 0);
      check("resp_valid", bif.resp_valid, cmp_ph == 2);
      check("rd_bus", bif.rd_bus, cmp_ph == 1 && !m_write);
      check("wr_bus", bif.wr_bus, cmp_ph == 1 && m_write);
      check("data_mask_bus", bif.data_mask_bus, (cmp_ph == 1) ? m_mask : 4'h0);
      check("addr_bus", bif.addr_bus, exp_addr);
      check("resp_rdata", bif.resp_rdata, cmp_done ? m_rdata : hold_rdata);
      check("resp_error", bif.resp_error, cmp_done ? m_err : hold_err);
      if (cmp_ph == 1 && m_write) check("data_bus write", data_bus, m_wdata);
      else if (cmp_ph != 1) check_released("data_bus idle");
    end
  end

  // ---------------- client driver ----------------------------------------
  task automatic drive_idle();
    bif.req_valid = 1'b0;
    bif.req_write = 1'($urandom);
    bif.req_addr  = $urandom;
    bif.req_wdata = $urandom;
    bif.req_mask  = 4'($urandom);
  endtask

  // Present a request from the next falling edge and hold it until taken.
  // acc = posedge number at which it was accepted.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] m, output int acc);
    logic r;
    @(negedge clk);
    bif.req_valid = 1'b1;
    bif.req_write = w;
    bif.req_addr  = a;
    bif.req_wdata = wd;
    bif.req_mask  = m;
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      r = bif.req_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept: request not taken within 100 cycles (cycle %0d)", cyc);
    end
  endtask

  // Drops the request and waits for resp_valid; latency is counted from the
  // cycle in which the request was accepted (acc-1), as a client sees it.
  task automatic wait_resp(input string name, input int acc, input int exp_lat,
                           input logic [31:0] exp_rdata, input logic exp_err);
    int at;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) drive_idle();
      if (bif.resp_valid) begin
        at = cyc;
        check({name, " rdata"}, bif.resp_rdata, exp_rdata);
        check({name, " error"}, bif.resp_error, exp_err);
        break;
      end
    end
    check({name, " latency"}, at - (acc - 1), exp_lat);
  endtask

  int a1, a2;
  logic        rw;
  logic [31:0] ra;
  logic [3:0]  rm;

  initial begin
    drive_idle();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Read 0x4, combinational responder
    do_req(1'b0, 32'h4, 32'hDEAD_BEEF, 4'hF, a1);
    wait_resp("read4", a1, 2, 32'h0100_0100, 1'b0);

    // Write 1 to 0x0, responder completes one cycle later
    do_req(1'b1, 32'h0, 32'h0000_0001, 4'h1, a1);
    wait_resp("write0", a1, 3, 32'h0, 1'b0);

    // Back-to-back: write then read held continuously
    do_req(1'b1, 32'h0, 32'hA5A5_0001, 4'h3, a1);
    do_req(1'b0, 32'h4, 32'h1234_5678, 4'hF, a2);
    check("b2b spacing", a2 - a1, 4);
    wait_resp("b2b read", a2, 2, 32'h0100_0100, 1'b0);

    // Zero mask is issued unchanged
    do_req(1'b1, 32'h10, 32'h7777_0000, 4'h0, a1);
    wait_resp("mask0 write", a1, 4, 32'h0, 1'b0);

`ifdef BUS_MASTER_TIMEOUT_EN
    do_req(1'b0, 32'h8000_0000, 32'h0, 4'hF, a1);
    wait_resp("timeout", a1, 5, 32'h0, 1'b1);
    do_req(1'b0, 32'h30, 32'h0, 4'hF, a1);
    wait_resp("fc on last", a1, 5, 32'h0C00_0C00, 1'b0);
`endif

    // Reset in the middle of a write
    do_req(1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, a1);
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst wr_bus", bif.wr_bus, 1'b0);
    check("midrst rd_bus", bif.rd_bus, 1'b0);
    check("midrst busy", bif.busy, 1'b0);
    check("midrst resp_valid", bif.resp_valid, 1'b0);
    check_released("midrst data_bus");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post-rst req_ready", bif.req_ready, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        drive_idle();
      end
      rw = 1'($urandom);
      ra = $urandom & 32'h7FFF_FFFF;
`ifdef BUS_MASTER_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) ra[31] = 1'b1;
`endif
      rm = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      do_req(rw, ra, $urandom, rm, a1);
    end
    @(negedge clk);
    drive_idle();
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
